mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. Consumes the 156-bit EXE→MEM bus, drives the synchronous data RAM for loads and stores, aligns and extends load data, and forwards a 119-bit MEM→WB bus to write-back. A small FSM covers the one-cycle RAM read latency and write-back back-pressure, and guarantees each store is written exactly once.

---
 rtl/mem_stage_pkg.sv | 44 ++++
 rtl/mem_align.sv | 63 ++++++
 rtl/mem_stage.sv | 122 ++++++++++++
 tb/tb_mem_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the EXE->MEM and MEM->WB buses, memory access sizes
// and the MEM-stage sequencing states.
package mem_stage_pkg;

  localparam int EXE_MEM_W = 156;
  localparam int MEM_WB_W  = 119;
  localparam int DATA_W    = 32;

  // EXE->MEM field offsets
  localparam int EM_CTRL_MSB  = 155;
  localparam int EM_CTRL_LSB  = 151;
  localparam int EM_RSVD      = 150;
  localparam int EM_SDATA_LSB = 118;
  localparam int EM_RES_LSB   = 86;
  localparam int EM_LO_LSB    = 54;
  localparam int EM_FLAGS_LSB = 48;
  localparam int EM_CP0R_LSB  = 40;
  localparam int EM_SYSCALL   = 39;
  localparam int EM_ERET      = 38;
  localparam int EM_RF_WEN    = 37;
  localparam int EM_WDEST_LSB = 32;
  localparam int EM_PC_LSB    = 0;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LOAD_WAIT = 2'b01,
    ST_DONE      = 2'b10
  } mem_state_e;

  typedef struct packed {
    logic      load;
    logic      store;
    mem_size_e size;
    logic      sign;
  } mem_ctrl_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data RAM: store enables and replicated write
// data, load lane extraction with zero/sign extension, and alignment checks.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic              mem_op,
  input  mem_size_e         size,
  input  logic              sign,
  input  logic [1:0]        a,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              addr_exc,
  output logic [3:0]        st_wen,
  output logic [DATA_W-1:0] st_wdata,
  output logic [DATA_W-1:0] ld_data
);

  function automatic logic [DATA_W-1:0] ext8(input logic signed [7:0] b, input logic sgn);
    logic signed [DATA_W-1:0] s;
    s = b;
    return sgn ? s : {24'b0, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext16(input logic signed [15:0] h, input logic sgn);
    logic signed [DATA_W-1:0] s;
    s = h;
    return sgn ? s : {16'b0, h};
  endfunction

  // Aligned accesses only ever shift by a legal lane offset, so one shifter
  // serves byte, half and word loads alike.
  logic [DATA_W-1:0] lane_sh;
  assign lane_sh = dm_rdata >> {a, 3'b000};

  assign addr_exc = mem_op && ((size == SIZE_ILL) ||
                               (size == SIZE_HALF && a[0]) ||
                               (size == SIZE_WORD && a != 2'b00));

  always_comb begin
    st_wen   = 4'b0000;
    st_wdata = store_data;
    ld_data  = lane_sh;
    case (size)
      SIZE_BYTE: begin
        st_wen   = 4'b0001 << a;
        st_wdata = {4{store_data[7:0]}};
        ld_data  = ext8(lane_sh[7:0], sign);
      end
      SIZE_HALF: begin
        st_wen   = a[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data[15:0]}};
        ld_data  = ext16(lane_sh[15:0], sign);
      end
      SIZE_WORD: begin
        st_wen = 4'b1111;
      end
      default: begin
        st_wen = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives the synchronous data RAM, covers its
// one-cycle read latency and write-back stalls, and forms the MEM->WB bus.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MEM_valid,
  input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
  input  logic                 WB_allow_in,
  input  logic [DATA_W-1:0]    dm_rdata,
  output logic [DATA_W-1:0]    dm_addr,
  output logic [3:0]           dm_wen,
  output logic [DATA_W-1:0]    dm_wdata,
  output logic                 MEM_over,
  output logic [MEM_WB_W-1:0]  MEM_WB_bus,
  output logic [4:0]           MEM_wdest,
  output logic [DATA_W-1:0]    MEM_pc
);

  mem_ctrl_t         ctrl;
  logic [DATA_W-1:0] store_data, exe_result, lo_result, pc;
  logic [5:0]        hilo_cp0_flags;
  logic [7:0]        cp0r_addr;
  logic              syscall, eret, rf_wen;
  logic [4:0]        rf_wdest;
  logic              unused_rsvd;

  assign ctrl           = mem_ctrl_t'(EXE_MEM_bus_r[EM_CTRL_MSB:EM_CTRL_LSB]);
  assign unused_rsvd    = EXE_MEM_bus_r[EM_RSVD];
  assign store_data     = EXE_MEM_bus_r[EM_SDATA_LSB +: DATA_W];
  assign exe_result     = EXE_MEM_bus_r[EM_RES_LSB +: DATA_W];
  assign lo_result      = EXE_MEM_bus_r[EM_LO_LSB +: DATA_W];
  assign hilo_cp0_flags = EXE_MEM_bus_r[EM_FLAGS_LSB +: 6];
  assign cp0r_addr      = EXE_MEM_bus_r[EM_CP0R_LSB +: 8];
  assign syscall        = EXE_MEM_bus_r[EM_SYSCALL];
  assign eret           = EXE_MEM_bus_r[EM_ERET];
  assign rf_wen         = EXE_MEM_bus_r[EM_RF_WEN];
  assign rf_wdest       = EXE_MEM_bus_r[EM_WDEST_LSB +: 5];
  assign pc             = EXE_MEM_bus_r[EM_PC_LSB +: DATA_W];

  logic              addr_exc;
  logic [3:0]        st_wen;
  logic [DATA_W-1:0] st_wdata, ld_data;

  mem_align u_align (
    .mem_op     (ctrl.load | ctrl.store),
    .size       (ctrl.size),
    .sign       (ctrl.sign),
    .a          (exe_result[1:0]),
    .store_data (store_data),
    .dm_rdata   (dm_rdata),
    .addr_exc   (addr_exc),
    .st_wen     (st_wen),
    .st_wdata   (st_wdata),
    .ld_data    (ld_data)
  );

  mem_state_e        state;
  logic [DATA_W-1:0] ld_buf;
  logic              ld_req;

  assign ld_req = ctrl.load && !addr_exc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      ld_buf <= '0;
    end else if (!MEM_valid) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ld_req)
            state <= ST_LOAD_WAIT;
          else if (!WB_allow_in)
            state <= ST_DONE;
        end
        ST_LOAD_WAIT: begin
          ld_buf <= ld_data;
          state  <= WB_allow_in ? ST_IDLE : ST_DONE;
        end
        ST_DONE: begin
          if (WB_allow_in)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Writes are only issued from IDLE, so a stalled store never repeats.
  assign dm_addr  = exe_result;
  assign dm_wdata = st_wdata;
  assign dm_wen   = (state == ST_IDLE && MEM_valid && ctrl.store && !addr_exc) ? st_wen : 4'b0000;

  always_comb begin
    MEM_over = 1'b0;
    if (MEM_valid) begin
      case (state)
        ST_IDLE:      MEM_over = !ld_req;
        ST_LOAD_WAIT: MEM_over = 1'b1;
        ST_DONE:      MEM_over = 1'b1;
        default:      MEM_over = 1'b0;
      endcase
    end
  end

  logic [DATA_W-1:0] mem_result;

  always_comb begin
    mem_result = exe_result;
    if (ld_req)
      mem_result = (state == ST_DONE) ? ld_buf : ld_data;
  end

  assign MEM_WB_bus = {addr_exc, mem_result, lo_result, hilo_cp0_flags, cp0r_addr,
                       syscall, eret, rf_wen && !addr_exc, rf_wdest, pc};
  assign MEM_wdest  = rf_wdest & {5{MEM_valid}};
  assign MEM_pc     = pc;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases from the stage's behaviour list plus
// randomized instructions against a transaction-level memory model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst, MEM_valid, WB_allow_in;
  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r;
  logic [31:0]          dm_rdata, dm_addr, dm_wdata, MEM_pc;
  logic [3:0]           dm_wen;
  logic                 MEM_over;
  logic [MEM_WB_W-1:0]  MEM_WB_bus;
  logic [4:0]           MEM_wdest;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .MEM_valid     (MEM_valid),
    .EXE_MEM_bus_r (EXE_MEM_bus_r),
    .WB_allow_in   (WB_allow_in),
    .dm_rdata      (dm_rdata),
    .dm_addr       (dm_addr),
    .dm_wen        (dm_wen),
    .dm_wdata      (dm_wdata),
    .MEM_over      (MEM_over),
    .MEM_WB_bus    (MEM_WB_bus),
    .MEM_wdest     (MEM_wdest),
    .MEM_pc        (MEM_pc)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [16];
  logic [31:0] ref_mem [16];
  logic        junk, pre_we;
  logic [3:0]  pre_idx;
  logic [31:0] pre_word;
  int          wr_count = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_res, last_wdata;
  logic        last_exc;
  logic [3:0]  last_wen;

  // Synchronous RAM; junk mode returns garbage to prove held load data.
  always @(posedge clk) begin
    if (pre_we) ram[pre_idx] <= pre_word;
    for (int i = 0; i < 4; i++)
      if (dm_wen[i]) ram[dm_addr[5:2]][8*i +: 8] <= dm_wdata[8*i +: 8];
    if (dm_wen != 4'b0000) wr_count <= wr_count + 1;
    dm_rdata <= junk ? $urandom : ram[dm_addr[5:2]];
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] a);
    longint v;
    if (sz == 2'd0) begin
      v = (w >> (8 * a)) & 255;
      if (sg && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = (w >> (8 * a)) & 65535;
      if (sg && v >= 32768) v = v - 65536;
    end else begin
      v = w;
    end
    return v[31:0];
  endfunction

  function automatic logic [EXE_MEM_W-1:0] make_bus(
      input logic ld, st, input logic [1:0] sz, input logic sg,
      input logic [31:0] addr, sdata, lo, input logic [5:0] flags, input logic [7:0] cp0r,
      input logic sys, eret, rfw, input logic [4:0] wdest, input logic [31:0] pc);
    return {ld, st, sz, sg, 1'b0, sdata, addr, lo, flags, cp0r, sys, eret, rfw, wdest, pc};
  endfunction

  function automatic logic [EXE_MEM_W-1:0] rand_bus(input logic ld, st, input logic [1:0] sz,
                                                    input logic sg, input logic [31:0] addr, sdata);
    return make_bus(ld, st, sz, sg, addr, sdata, $urandom, 6'($urandom), 8'($urandom),
                    1'($urandom), 1'($urandom), 1'b1, 5'($urandom_range(1, 31)), $urandom);
  endfunction

  // Issue one instruction at a negedge, hold it until handshake, return at a negedge.
  task automatic run_instr(input logic ld, st, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, sdata, input int stall);
    logic [31:0]         lo, pc, exp_res, exp_wdata;
    logic [5:0]          flags;
    logic [7:0]          cp0r;
    logic                sys, eret, rfw, exc;
    logic [4:0]          wdest;
    logic [3:0]          exp_wen;
    logic [MEM_WB_W-1:0] exp_bus;
    int                  lat, cyc, wr0;
    bit                  seen, done;
    lo = $urandom; pc = $urandom; flags = 6'($urandom); cp0r = 8'($urandom);
    sys = 1'($urandom); eret = 1'($urandom); rfw = 1'($urandom); wdest = 5'($urandom);
    exc = (ld || st) && (sz == 2'd3 || (sz == 2'd1 && addr % 2 != 0) ||
                         (sz == 2'd2 && addr % 4 != 0));
    exp_wen = 4'b0000;
    exp_wdata = sdata;
    if (st && !exc) begin
      if (sz == 2'd0) begin
        exp_wen = 4'b0001 << addr[1:0];
        exp_wdata = {24'b0, sdata[7:0]} * 32'h01010101;
      end else if (sz == 2'd1) begin
        exp_wen = addr[1] ? 4'b1100 : 4'b0011;
        exp_wdata = {16'b0, sdata[15:0]} * 32'h00010001;
      end else begin
        exp_wen = 4'b1111;
      end
    end
    exp_res = (ld && !exc) ? ref_load(ref_mem[addr[5:2]], sz, sg, addr[1:0]) : addr;
    lat = (ld && !exc) ? 2 : 1;
    exp_bus = {exc, exp_res, lo, flags, cp0r, sys, eret, rfw && !exc, wdest, pc};

    MEM_valid = 1'b1;
    EXE_MEM_bus_r = make_bus(ld, st, sz, sg, addr, sdata, lo, flags, cp0r, sys, eret, rfw, wdest, pc);
    junk = 1'b0;
    wr0 = wr_count;
    seen = 0; done = 0; cyc = 0;
    while (!done && cyc < 16) begin
      cyc++;
      WB_allow_in = (cyc >= lat + stall);
      #1;
      if (cyc == 1) begin
        check("dm_addr", dm_addr, addr);
        check("dm_wen", dm_wen, exp_wen);
        last_wen = dm_wen;
        last_wdata = dm_wdata;
        if (exp_wen != 4'b0000) check("dm_wdata", dm_wdata, exp_wdata);
      end else begin
        check("dm_wen_stall", dm_wen, 4'b0000);
      end
      if (MEM_over) begin
        if (!seen) check("latency", cyc, lat);
        seen = 1;
        check("wb_bus", MEM_WB_bus, exp_bus);
        check("wdest", MEM_wdest, wdest);
        check("pc", MEM_pc, pc);
        last_res = MEM_WB_bus[117:86];
        last_exc = MEM_WB_bus[118];
        if (ld && !exc) junk = 1'b1;
        done = WB_allow_in;
      end
      @(negedge clk);
    end
    junk = 1'b0;
    check("handshake", done, 1'b1);
    check("writes", wr_count - wr0, (st && !exc) ? 1 : 0);
    if (st && !exc)
      for (int i = 0; i < 4; i++)
        if (exp_wen[i]) ref_mem[addr[5:2]][8*i +: 8] = exp_wdata[8*i +: 8];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    rst = 1'b1; MEM_valid = 1'b0; WB_allow_in = 1'b1; junk = 1'b0; pre_we = 1'b0;
    pre_idx = '0; pre_word = '0;
    EXE_MEM_bus_r = make_bus(0, 1, 2'd2, 0, 32'h0, 32'h1, 32'h0, 6'h0, 8'h0, 0, 0, 1, 5'h1F, 32'h0);
    for (int i = 0; i < 16; i++) begin
      w = (i == 0) ? 32'h12F45678 : (i == 8) ? 32'hCAFEF00D : $urandom;
      ref_mem[i] = w;
      @(negedge clk);
      pre_we = 1'b1; pre_idx = i[3:0]; pre_word = w;
    end
    @(negedge clk);
    pre_we = 1'b0;
    #1;
    check("rst_over", MEM_over, 1'b0);
    check("rst_wen", dm_wen, 4'b0000);
    check("rst_wdest", MEM_wdest, 5'd0);
    @(negedge clk);
    rst = 1'b0;

    run_instr(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
    check("sw_wen", last_wen, 4'b1111);
    check("sw_wdata", last_wdata, 32'hDEADBEEF);
    run_instr(0, 1, 2'd0, 0, 32'h13, 32'h000000A5, 3);
    check("sb_wen", last_wen, 4'b1000);
    check("sb_wdata", last_wdata, 32'hA5A5A5A5);
    run_instr(1, 0, 2'd0, 1, 32'h02, 32'h0, 0);
    check("lb_res", last_res, 32'hFFFFFFF4);
    run_instr(1, 0, 2'd0, 0, 32'h02, 32'h0, 1);
    check("lbu_res", last_res, 32'h000000F4);
    run_instr(1, 0, 2'd1, 1, 32'h01, 32'h0, 0);
    check("lh_exc_res", last_res, 32'h00000001);
    check("lh_exc_flag", last_exc, 1'b1);
    run_instr(1, 0, 2'd2, 0, 32'h20, 32'h0, 2);
    check("lw_hold_res", last_res, 32'hCAFEF00D);

    // Reset while a load sits in LOAD_WAIT under a write-back stall.
    MEM_valid = 1'b1; WB_allow_in = 1'b0;
    EXE_MEM_bus_r = rand_bus(1, 0, 2'd2, 0, 32'h24, 32'h0);
    #1 check("rml_c1_over", MEM_over, 1'b0);
    @(negedge clk);
    #1 check("rml_lw_over", MEM_over, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    #1 check("rml_rst_over", MEM_over, 1'b0);
    check("rml_rst_wen", dm_wen, 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    #1 check("rml_again_over", MEM_over, 1'b1);
    check("rml_data", MEM_WB_bus[117:86], ref_mem[9]);
    WB_allow_in = 1'b1;
    @(negedge clk);

    // Dropping MEM_valid mid-load must return to IDLE so the next store writes.
    EXE_MEM_bus_r = rand_bus(1, 0, 2'd2, 0, 32'h28, 32'h0);
    WB_allow_in = 1'b0;
    @(negedge clk);
    #1 check("drop_lw_over", MEM_over, 1'b1);
    MEM_valid = 1'b0;
    @(negedge clk);
    #1 check("drop_over", MEM_over, 1'b0);
    run_instr(0, 1, 2'd2, 0, 32'h2C, $urandom, 0);

    for (int n = 0; n < 300; n++) begin
      int kind;
      if ($urandom_range(0, 3) == 0) begin
        MEM_valid = 1'b0;
        EXE_MEM_bus_r = rand_bus(0, 1, 2'd2, 0, 32'h0, $urandom);
        WB_allow_in = 1'($urandom);
        #1;
        check("bubble_over", MEM_over, 1'b0);
        check("bubble_wen", dm_wen, 4'b0000);
        check("bubble_wdest", MEM_wdest, 5'd0);
        @(negedge clk);
      end
      kind = $urandom_range(0, 2);
      run_instr(kind == 1, kind == 2, 2'($urandom), 1'($urandom), $urandom_range(0, 63),
                $urandom, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
